// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFILL  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
interface icache_if;

  logic                        fetch_req;
  logic [icache_pkg::XLEN-1:0] fetch_pc;
  logic                        inst_ready;
  logic [icache_pkg::XLEN-1:0] inst;
  logic [icache_pkg::XLEN-1:0] inst_addr;
  logic                        busy;
  logic                        mem_req;
  logic [icache_pkg::XLEN-1:0] mem_addr;
  logic                        mem_ack;
  logic [icache_pkg::XLEN-1:0] mem_data;

  // Cache side
  modport master (
    input  fetch_req, fetch_pc, mem_ack, mem_data,
    output inst_ready, inst, inst_addr, busy, mem_req, mem_addr
  );

  // Fetch unit and memory controller side
  modport slave (
    output fetch_req, fetch_pc, mem_ack, mem_data,
    input  inst_ready, inst, inst_addr, busy, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write, async valid clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - WORD_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [WORD_BITS-1:0]  rd_word,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [XLEN-1:0]       rd_data,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [WORD_BITS-1:0]  wr_word,
  input  logic                  data_we,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  tag_we,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic                  inval_we
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [XLEN-1:0]     data [LINES][WORDS];

  // Only the valid bits are reset; stale tags/data are harmless while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[wr_idx] <= 1'b1;
    end else if (inval_we) begin
      valid[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data[wr_idx][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache top: lookup/refill FSM and response registers.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  icache_if.master     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IDX_LSB  = WORD_BITS + 2;
  localparam int TAG_LSB  = INDEX_BITS + WORD_BITS + 2;
  localparam int TAG_BITS = XLEN - TAG_LSB;
  localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

  state_t               state;
  logic [XLEN-1:0]      pc_q;
  logic [WORD_BITS-1:0] cnt;
  logic [WORD_BITS-1:0] cnt_nxt;
  logic                 drop;

  logic [INDEX_BITS-1:0] req_idx, lat_idx, rd_idx;
  logic [WORD_BITS-1:0]  req_word, lat_word, rd_word;
  logic [TAG_BITS-1:0]   req_tag, lat_tag, rd_tag;
  logic                  rd_valid;
  logic [XLEN-1:0]       rd_data;
  logic                  lookup, hit, fill_we, tag_we, inval_we, last;

  assign req_idx  = bus.fetch_pc[TAG_LSB-1:IDX_LSB];
  assign req_word = bus.fetch_pc[IDX_LSB-1:2];
  assign req_tag  = bus.fetch_pc[XLEN-1:TAG_LSB];
  assign lat_idx  = pc_q[TAG_LSB-1:IDX_LSB];
  assign lat_word = pc_q[IDX_LSB-1:2];
  assign lat_tag  = pc_q[XLEN-1:TAG_LSB];

  // IDLE looks up the incoming PC; REFILL/RESPOND work on the latched PC.
  assign rd_idx  = (state == S_IDLE) ? req_idx  : lat_idx;
  assign rd_word = (state == S_IDLE) ? req_word : lat_word;

  assign lookup   = rdy && (state == S_IDLE) && bus.fetch_req && !clear;
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign last     = (cnt == LAST_WORD);
  assign cnt_nxt  = cnt + 1'b1;
  assign fill_we  = rdy && (state == S_REFILL) && bus.mem_ack;
  assign tag_we   = fill_we && last;
  assign inval_we = lookup && !hit;

  assign bus.busy = (state != S_IDLE);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_word  (rd_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_idx   (rd_idx),
    .wr_word  (cnt),
    .data_we  (fill_we),
    .wr_data  (bus.mem_data),
    .tag_we   (tag_we),
    .wr_tag   (lat_tag),
    .inval_we (inval_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      pc_q           <= '0;
      cnt            <= '0;
      drop           <= 1'b0;
      bus.inst_ready <= 1'b0;
      bus.inst       <= '0;
      bus.inst_addr  <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
    end else if (rdy) begin
      bus.inst_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          drop <= 1'b0;
          if (lookup) begin
            pc_q <= bus.fetch_pc;
            if (hit) begin
              bus.inst_ready <= 1'b1;
              bus.inst       <= rd_data;
              bus.inst_addr  <= bus.fetch_pc;
            end else begin
              state        <= S_REFILL;
              cnt          <= '0;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.fetch_pc[XLEN-1:IDX_LSB], {WORD_BITS{1'b0}}, 2'b00};
            end
          end
        end
        S_REFILL: begin
          // A flush only suppresses the response; the line fill always completes.
          if (clear) begin
            drop <= 1'b1;
          end
          if (bus.mem_ack) begin
            if (last) begin
              bus.mem_req <= 1'b0;
              state       <= S_RESPOND;
            end else begin
              cnt          <= cnt_nxt;
              bus.mem_addr <= {pc_q[XLEN-1:IDX_LSB], cnt_nxt, 2'b00};
            end
          end
        end
        S_RESPOND: begin
          if (!(drop || clear)) begin
            bus.inst_ready <= 1'b1;
            bus.inst       <= rd_data;
            bus.inst_addr  <= pc_q;
          end
          drop  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lookup) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
